// File: rtl/game_pkg.sv
// Shared definitions for the reaction-game round sequencer: state encoding,
// LED width, LFSR taps/seed and small pure helpers used by the controller.
package game_pkg;

  localparam int LED_W  = 8;
  localparam int LFSR_W = 16;
  localparam int IDX_W  = $clog2(LED_W);

  // Taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int                DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam logic [LFSR_W-1:0] DEFAULT_LFSR_SEED       = 16'hACE1;

  localparam logic [7:0] SCORE_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ARM          = 3'd1,
    WAIT_MATCH   = 3'd2,
    WAIT_RELEASE = 3'd3,
    OVER         = 3'd4
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Never repeat the same LED twice in a row: bump a repeated index by one.
  function automatic logic [IDX_W-1:0] pick_index(input logic [IDX_W-1:0] raw,
                                                   input logic [IDX_W-1:0] prev);
    logic [IDX_W-1:0] bumped;
    bumped = raw + IDX_W'(1);
    return (raw == prev) ? bumped : raw;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser per player input followed by a whole-vector debouncer:
// deb only takes a new value once the synced vector has held it for DEBOUNCE_CYCLES.
module input_debouncer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LED_W-1:0] raw,
  output logic [LED_W-1:0] deb
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [LED_W-1:0] sync_meta;
  logic [LED_W-1:0] sync_out;
  logic [LED_W-1:0] candidate;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] stable_cnt_next;
  logic             changed;

  assign changed = (sync_out != candidate);

  // The cycle a new value appears counts as its first stable cycle; the count
  // saturates so a long-held vector keeps deb pinned without wrapping.
  always_comb begin
    stable_cnt_next = stable_cnt;
    if (changed) begin
      stable_cnt_next = CNT_W'(1);
    end else if (stable_cnt != CNT_MAX) begin
      stable_cnt_next = stable_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta  <= '0;
      sync_out   <= '0;
      candidate  <= '0;
      stable_cnt <= '0;
      deb        <= '0;
    end else begin
      sync_meta  <= raw;
      sync_out   <= sync_meta;
      stable_cnt <= stable_cnt_next;
      if (changed) begin
        candidate <= sync_out;
      end else if (stable_cnt_next == CNT_MAX) begin
        deb <= candidate;
      end
    end
  end

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer: debounced player inputs, pseudo-random one-hot target,
// match detection, saturating score and game start/stop handshake with the timer.
module round_controller
  import game_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [LFSR_W-1:0] LFSR_SEED       = DEFAULT_LFSR_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             timer_done,
  input  logic [LED_W-1:0] buttons,
  output logic [LED_W-1:0] target,
  output logic [7:0]       score,
  output logic             hit,
  output logic             playing,
  output logic             game_over,
  output logic             timer_restart
);

  state_t            state;
  state_t            next_state;
  logic [LED_W-1:0]  deb;
  logic [LFSR_W-1:0] lfsr;
  logic [IDX_W-1:0]  prev_idx;
  logic [IDX_W-1:0]  pick_idx;
  logic [LED_W-1:0]  pick_target;

  logic [LED_W-1:0]  target_d;
  logic [7:0]        score_d;
  logic              hit_d;
  logic              playing_d;
  logic              game_over_d;
  logic              timer_restart_d;
  logic [IDX_W-1:0]  prev_idx_d;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .reset(reset),
    .raw  (buttons),
    .deb  (deb)
  );

  // Free-running so the pattern depends on how long the player waited.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign pick_idx    = pick_index(lfsr[IDX_W-1:0], prev_idx);
  assign pick_target = LED_W'(1) << pick_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // timer_done is checked before the match so an expiring timer always wins.
  always_comb begin
    next_state      = state;
    target_d        = target;
    score_d         = score;
    hit_d           = 1'b0;
    timer_restart_d = 1'b0;
    prev_idx_d      = prev_idx;

    case (state)
      IDLE, OVER: begin
        if (start) begin
          next_state = ARM;
        end
      end

      ARM: begin
        score_d         = 8'd0;
        timer_restart_d = 1'b1;
        target_d        = pick_target;
        prev_idx_d      = pick_idx;
        next_state      = WAIT_MATCH;
      end

      WAIT_MATCH: begin
        if (timer_done) begin
          next_state = OVER;
        end else if (deb == target) begin
          hit_d      = 1'b1;
          next_state = WAIT_RELEASE;
          if (score != SCORE_MAX) begin
            score_d = score + 8'd1;
          end
        end
      end

      WAIT_RELEASE: begin
        if (timer_done) begin
          next_state = OVER;
        end else if (deb == '0) begin
          target_d   = pick_target;
          prev_idx_d = pick_idx;
          next_state = WAIT_MATCH;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    if (next_state == IDLE || next_state == OVER) begin
      target_d = '0;
    end
    playing_d   = (next_state == ARM) || (next_state == WAIT_MATCH) ||
                  (next_state == WAIT_RELEASE);
    game_over_d = (next_state == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target        <= '0;
      score         <= 8'd0;
      hit           <= 1'b0;
      playing       <= 1'b0;
      game_over     <= 1'b0;
      timer_restart <= 1'b0;
      prev_idx      <= '0;
    end else begin
      target        <= target_d;
      score         <= score_d;
      hit           <= hit_d;
      playing       <= playing_d;
      game_over     <= game_over_d;
      timer_restart <= timer_restart_d;
      prev_idx      <= prev_idx_d;
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: a game-level reference model checked every cycle,
// plus directed scenarios with hand-derived literal expectations.
module tb_round_controller;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       timer_done = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic [7:0] target;
  logic [7:0] score;
  logic       hit;
  logic       playing;
  logic       game_over;
  logic       timer_restart;

  int checks = 0;
  int errors = 0;
  int hitTotal = 0;

  round_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .timer_done   (timer_done),
    .buttons      (buttons),
    .target       (target),
    .score        (score),
    .hit          (hit),
    .playing      (playing),
    .game_over    (game_over),
    .timer_restart(timer_restart)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: game phases, raw-input history and LFSR kept as plain values.
  typedef enum int {M_IDLE, M_ARMING, M_HUNT, M_HELD, M_DONE} mode_t;

  mode_t      mMode = M_IDLE;
  logic [7:0] mHist [DEB+2];
  logic [7:0] mDeb = 8'h00;
  logic [15:0] mLfsr = 16'hACE1;
  int         mPrev = 0;
  logic [7:0] mTarget = 8'h00;
  int         mScore = 0;
  logic       mHit = 1'b0;
  logic       mRestart = 1'b0;
  logic       mPlaying = 1'b0;
  logic       mOver = 1'b0;

  function automatic void pickTarget();
    int idx;
    idx = int'(mLfsr % 16'd8);
    if (idx == mPrev) idx = (idx + 1) % 8;
    mPrev   = idx;
    mTarget = 8'd1 << idx;
  endfunction

  function automatic void endGame();
    mMode    = M_DONE;
    mOver    = 1'b1;
    mPlaying = 1'b0;
    mTarget  = 8'h00;
  endfunction

  always @(posedge clk) begin
    logic stable;
    if (reset) begin
      mMode = M_IDLE; mDeb = 8'h00; mLfsr = 16'hACE1; mPrev = 0;
      mTarget = 8'h00; mScore = 0; mHit = 1'b0; mRestart = 1'b0;
      mPlaying = 1'b0; mOver = 1'b0;
      for (int i = 0; i < DEB + 2; i++) mHist[i] = 8'h00;
    end else begin
      mHit = 1'b0;
      mRestart = 1'b0;
      case (mMode)
        M_IDLE, M_DONE: if (start) begin mMode = M_ARMING; mPlaying = 1'b1; mOver = 1'b0; end
        M_ARMING: begin mScore = 0; mRestart = 1'b1; pickTarget(); mMode = M_HUNT; end
        M_HUNT: begin
          if (timer_done) endGame();
          else if (mDeb == mTarget) begin
            mHit = 1'b1;
            mScore = (mScore < 255) ? mScore + 1 : 255;
            mMode = M_HELD;
          end
        end
        M_HELD: begin
          if (timer_done) endGame();
          else if (mDeb == 8'h00) begin pickTarget(); mMode = M_HUNT; end
        end
        default: mMode = M_IDLE;
      endcase
      // deb follows raw once DEB consecutive samples, two edges old, agree.
      for (int i = DEB + 1; i > 0; i--) mHist[i] = mHist[i-1];
      mHist[0] = buttons;
      stable = 1'b1;
      for (int i = 3; i <= DEB + 1; i++) if (mHist[i] != mHist[2]) stable = 1'b0;
      if (stable) mDeb = mHist[2];
      mLfsr = {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
    end
    #1;
    checkOutput("model_target", target, mTarget);
    checkOutput("model_score", score, mScore);
    checkOutput("model_hit", hit, mHit);
    checkOutput("model_playing", playing, mPlaying);
    checkOutput("model_game_over", game_over, mOver);
    checkOutput("model_timer_restart", timer_restart, mRestart);
  end

  always @(negedge clk) if (hit === 1'b1) hitTotal++;

  // Called on a falling edge: drive inputs, then wait the given number of falling edges.
  task automatic applyStimulus(input logic s, input logic td, input logic [7:0] b,
                               input int cycles);
    start      = s;
    timer_done = td;
    buttons    = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doHit();
    applyStimulus(1'b0, 1'b0, mTarget, 8);
    applyStimulus(1'b0, 1'b0, 8'h00, 8);
  endtask

  initial begin
    logic [7:0] prevTarget;
    logic [7:0] wrong;
    int hitsSeen;
    int hitAt;
    int hitBase;

    repeat (3) @(negedge clk);
    checkOutput("reset_target", target, 8'h00);
    checkOutput("reset_score", score, 8'd0);
    checkOutput("reset_playing", playing, 1'b0);
    checkOutput("reset_game_over", game_over, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 2);

    // Start; timer_done held only during ARM must not end the game.
    applyStimulus(1'b1, 1'b0, 8'h00, 1);
    checkOutput("arm_playing", playing, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1);
    checkOutput("start_restart", timer_restart, 1'b1);
    checkOutput("start_onehot", $countones(target), 1);
    checkOutput("start_score", score, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("restart_single", timer_restart, 1'b0);
    checkOutput("armdone_playing", playing, 1'b1);
    checkOutput("armdone_over", game_over, 1'b0);

    // Matching press: hit exactly once, 7 cycles after the change.
    prevTarget = mTarget;
    buttons = mTarget;
    hitsSeen = 0;
    hitAt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #2;
      if (hit === 1'b1) begin hitsSeen++; hitAt = i; end
    end
    @(negedge clk);
    checkOutput("hit_count", hitsSeen, 1);
    checkOutput("hit_latency", hitAt, 7);
    checkOutput("hit_score", score, 8'd1);
    checkOutput("hold_target", target, prevTarget);

    applyStimulus(1'b0, 1'b0, 8'h00, 8);
    checkOutput("new_onehot", $countones(target), 1);
    checkOutput("new_differs", target != prevTarget, 1'b1);

    // Wrong pattern and a 3-cycle glitch are both ignored.
    wrong = (mTarget == 8'h01) ? 8'h03 : (mTarget | 8'h01);
    applyStimulus(1'b0, 1'b0, wrong, 10);
    checkOutput("wrong_score", score, 8'd1);
    applyStimulus(1'b0, 1'b0, mTarget, 3);
    applyStimulus(1'b0, 1'b0, 8'h00, 10);
    checkOutput("glitch_score", score, 8'd1);
    checkOutput("glitch_playing", playing, 1'b1);

    // timer_done arrives the same cycle deb matches.
    applyStimulus(1'b0, 1'b0, mTarget, 6);
    applyStimulus(1'b0, 1'b1, mTarget, 1);
    checkOutput("tie_game_over", game_over, 1'b1);
    checkOutput("tie_target", target, 8'h00);
    checkOutput("tie_hit", hit, 1'b0);
    checkOutput("tie_score", score, 8'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 8);

    // Restart from OVER, then saturate the score.
    applyStimulus(1'b1, 1'b0, 8'h00, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("restart_score", score, 8'd0);
    checkOutput("restart_pulse", timer_restart, 1'b1);
    hitBase = hitTotal;
    for (int k = 0; k < 256; k++) doHit();
    checkOutput("sat_hits", hitTotal - hitBase, 256);
    checkOutput("sat_score", score, 8'd255);

    applyStimulus(1'b0, 1'b1, 8'h00, 2);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("over_flag", game_over, 1'b1);
    checkOutput("over_score", score, 8'd255);
    applyStimulus(1'b1, 1'b0, 8'h00, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("over_start_score", score, 8'd0);
    checkOutput("over_start_restart", timer_restart, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1);
    checkOutput("over_restart_single", timer_restart, 1'b0);

    // Score 5 held in WAIT_RELEASE; start ignored, then reset mid-game.
    for (int k = 0; k < 4; k++) doHit();
    applyStimulus(1'b0, 1'b0, mTarget, 8);
    checkOutput("five_score", score, 8'd5);
    applyStimulus(1'b1, 1'b0, buttons, 1);
    applyStimulus(1'b0, 1'b0, buttons, 2);
    checkOutput("ignore_start_playing", playing, 1'b1);
    checkOutput("ignore_start_score", score, 8'd5);
    checkOutput("ignore_start_restart", timer_restart, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_score", score, 8'd0);
    checkOutput("midreset_target", target, 8'h00);
    checkOutput("midreset_playing", playing, 1'b0);
    checkOutput("midreset_over", game_over, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 4);
    checkOutput("idle_after_reset", playing, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
